// File: rtl/note_sequencer_if.sv
// note_sequencer_if: bundles the VGA position, playback controls and the
// lane strobe / status outputs of the note sequencer.
// master: the game / video side that drives position and controls.
// slave : the note_sequencer itself.
interface note_sequencer_if;
    logic [9:0] row;
    logic [9:0] col;
    logic       start;
    logic       pause;
    logic       loop_en;
    logic [4:0] drop;
    logic       step_strobe;
    logic [4:0] step_idx;
    logic       playing;
    logic       song_done;

    modport master (
        output row, col, start, pause, loop_en,
        input  drop, step_strobe, step_idx, playing, song_done
    );

    modport slave (
        input  row, col, start, pause, loop_en,
        output drop, step_strobe, step_idx, playing, song_done
    );
endinterface

// File: rtl/note_sequencer.sv
// note_sequencer: steps a fixed five-lane note chart at a frame-locked tempo
// and issues one-clock drop strobes to the lane generators.
// drop bit order is {white, orange, blue, yellow, green}.
// Optional feature macro: NOTE_SEQ_LEADIN_EN -- when defined, four silent
// lead-in steps (step_strobe only) run before chart step 0 on entry to PLAY.
module note_sequencer #(
    parameter int                   CHART_LEN       = 21,
    parameter int                   FRAMES_PER_STEP = 15,
    parameter logic [CHART_LEN-1:0] GREEN_CHART     = '0,
    parameter logic [CHART_LEN-1:0] YELLOW_CHART    = '0,
    parameter logic [CHART_LEN-1:0] BLUE_CHART      = '0,
    parameter logic [CHART_LEN-1:0] ORANGE_CHART    = '0,
    parameter logic [CHART_LEN-1:0] WHITE_CHART     = '0,
    parameter logic [9:0]           FRAME_ROW       = 10'd480
) (
    input  logic              clk,
    input  logic              reset,
    note_sequencer_if.slave   bus
);

    localparam logic [4:0] LAST_STEP  = 5'(CHART_LEN - 1);
    localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Lane pattern for chart step k. Explicit loop so the step index never
    // needs to match the chart vector's index width.
    function automatic logic [4:0] chart_bits(input logic [4:0] k);
        logic [4:0] v;
        v = 5'b00000;
        for (int i = 0; i < CHART_LEN; i++) begin
            if (5'(i) == k) begin
                v = {WHITE_CHART[i], ORANGE_CHART[i], BLUE_CHART[i],
                     YELLOW_CHART[i], GREEN_CHART[i]};
            end
        end
        return v;
    endfunction

    state_t     r_state;
    logic [7:0] r_frame_cnt;
    logic [4:0] r_step_idx;
    logic       r_first;
    logic [4:0] r_drop;
    logic       r_step_strobe;
    logic       r_playing;
    logic       r_song_done;
    logic       r_match_d;
`ifdef NOTE_SEQ_LEADIN_EN
    logic       r_leadin_act;
    logic [2:0] r_leadin_cnt;
`endif

    logic       w_frame_match;
    logic       w_tick;

    // Frame condition and its rising edge: a held col==0 yields one tick.
    always_comb begin
        w_frame_match = 1'b0;
        w_tick        = 1'b0;
        if ((bus.row == FRAME_ROW) && (bus.col == 10'd0)) begin
            w_frame_match = 1'b1;
        end else begin
            w_frame_match = 1'b0;
        end
        w_tick = w_frame_match & ~r_match_d;
    end

    // Remember last cycle's frame condition for the edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_match_d <= 1'b0;
        end else begin
            r_match_d <= w_frame_match;
        end
    end

    // Playback state machine; every output is a register written here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_frame_cnt   <= 8'd0;
            r_step_idx    <= 5'd0;
            r_first       <= 1'b0;
            r_drop        <= 5'b00000;
            r_step_strobe <= 1'b0;
            r_playing     <= 1'b0;
            r_song_done   <= 1'b0;
`ifdef NOTE_SEQ_LEADIN_EN
            r_leadin_act  <= 1'b0;
            r_leadin_cnt  <= 3'd0;
`endif
        end else begin
            // Strobes are single-cycle unless a branch below re-asserts them.
            r_drop        <= 5'b00000;
            r_step_strobe <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start && !bus.pause) begin
                        r_state     <= ST_PLAY;
                        r_frame_cnt <= 8'd0;
                        r_step_idx  <= 5'd0;
                        r_first     <= 1'b1;
                        r_playing   <= 1'b1;
                        r_song_done <= 1'b0;
`ifdef NOTE_SEQ_LEADIN_EN
                        r_leadin_act <= 1'b0;
                        r_leadin_cnt <= 3'd0;
`endif
                    end else begin
                        r_state <= r_state;
                    end
                end
                ST_PLAY: begin
                    if (bus.pause) begin
                        // Pause wins over a coincident tick.
                        r_state <= ST_PAUSED;
                    end else if (w_tick) begin
                        if (r_first) begin
                            r_first <= 1'b0;
`ifdef NOTE_SEQ_LEADIN_EN
                            // First lead-in step starts on the first tick.
                            r_leadin_act  <= 1'b1;
                            r_leadin_cnt  <= 3'd1;
                            r_step_strobe <= 1'b1;
`else
                            r_drop        <= chart_bits(5'd0);
                            r_step_strobe <= 1'b1;
                            r_step_idx    <= 5'd0;
`endif
                        end else if (r_frame_cnt == LAST_FRAME) begin
                            r_frame_cnt <= 8'd0;
`ifdef NOTE_SEQ_LEADIN_EN
                            if (r_leadin_act) begin
                                if (r_leadin_cnt == 3'd4) begin
                                    // Lead-in over: chart step 0 now.
                                    r_leadin_act  <= 1'b0;
                                    r_drop        <= chart_bits(5'd0);
                                    r_step_strobe <= 1'b1;
                                    r_step_idx    <= 5'd0;
                                end else begin
                                    r_leadin_cnt  <= r_leadin_cnt + 3'd1;
                                    r_step_strobe <= 1'b1;
                                end
                            end else begin
`endif
                            if (r_step_idx == LAST_STEP) begin
                                if (bus.loop_en) begin
                                    r_drop        <= chart_bits(5'd0);
                                    r_step_strobe <= 1'b1;
                                    r_step_idx    <= 5'd0;
                                end else begin
                                    // Song over: no strobe, index stays at last.
                                    r_state     <= ST_DONE;
                                    r_playing   <= 1'b0;
                                    r_song_done <= 1'b1;
                                end
                            end else begin
                                r_drop        <= chart_bits(r_step_idx + 5'd1);
                                r_step_strobe <= 1'b1;
                                r_step_idx    <= r_step_idx + 5'd1;
                            end
`ifdef NOTE_SEQ_LEADIN_EN
                            end
`endif
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                        end
                    end else begin
                        r_state <= ST_PLAY;
                    end
                end
                ST_PAUSED: begin
                    // Counter, index and first flag stay frozen here.
                    if (!bus.pause) begin
                        r_state <= ST_PLAY;
                    end else begin
                        r_state <= ST_PAUSED;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_playing <= 1'b0;
                end
            endcase
        end
    end

    assign bus.drop        = r_drop;
    assign bus.step_strobe = r_step_strobe;
    assign bus.step_idx    = r_step_idx;
    assign bus.playing     = r_playing;
    assign bus.song_done   = r_song_done;

endmodule
